ocx_tlx_fifo_drain_serializer: RTL
==================================

# ocx_tlx_fifo_drain_serializer

Read-side consumer of the TLX 513-bit x 32-entry data FIFO. It pops one 513-bit entry at a time: bits 511:0 carry payload and bit 512 is the bad-data flag. It then serializes the payload into BEAT_WIDTH-bit beats on a valid/ready stream toward the transmit framer. It sits between the FIFO and the framer; the parent instantiates the FIFO.

## Interface
- BEAT_WIDTH, 128, payload bits per output beat; legal values are 64, 128 and 256. NUM_BEATS = 512/BEAT_WIDTH.
- clock  in  1  single clock for the whole block.
- reset_n  in  1  reset; synchronous and active-low.
- fifo_data_out  in  513  head entry from the FIFO; valid while fifo_data_available=1.
- fifo_data_available  in  1  FIFO head holds a valid entry.
- fifo_data_look_ahead  in  1  FIFO holds at least one entry beyond the head. Status only; does not gate any decision.
- fifo_underflow_error  in  1  FIFO error pulse.
- fifo_overflow_error  in  1  FIFO error pulse.
- fifo_rd_done  out  1  one-cycle pop pulse to the FIFO.
- tx_valid  out  1  beat valid.
- tx_ready  in  1  downstream accepts the beat.
- tx_data  out  BEAT_WIDTH  beat payload.
- tx_first  out  1  marks beat 0 of an entry.
- tx_last  out  1  marks beat NUM_BEATS-1 of an entry.
- tx_bad  out  1  copy of entry bit 512, driven on every beat of that entry.
- entries_sent  out  16  count of entries whose last beat was accepted; wraps from 0xFFFF to 0.
- fifo_error_sticky  out  1  set when either FIFO error input is high; cleared only by reset.

## Operation
- Holding register hold[512:0], beat counter beat (log2 NUM_BEATS bits), and a one-bit flag rd_done_q (fifo_rd_done delayed by one cycle).
- States: IDLE and SEND.
- Capture condition: fifo_data_available=1 and rd_done_q=0. On capture:
  - hold <= fifo_data_out
  - fifo_rd_done=1 in the same cycle
  - beat <= 0
  - next state is SEND
- rd_done_q blanks capture for the cycle after each pop. The FIFO's available/data outputs are stale in that cycle.
- IDLE: tx_valid=0. Capture when the capture condition holds.
- SEND:
  - tx_valid=1
  - tx_data = hold[beat*BEAT_WIDTH +: BEAT_WIDTH], so beat 0 carries bits BEAT_WIDTH-1:0
  - tx_first = (beat==0); tx_last = (beat==NUM_BEATS-1); tx_bad = hold[512]
- A beat is accepted when tx_valid and tx_ready are both 1. A non-last accepted beat increments beat.
- Last beat accepted:
  - entries_sent increments.
  - If the capture condition holds in that same cycle: capture the next entry and stay in SEND with beat=0. This gives back-to-back entries with no bubble.
  - Otherwise go to IDLE.
- Stream rules:
  - tx_data, tx_first, tx_last and tx_bad are stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without an acceptance.
  - tx_ready may be high while tx_valid=0; it has no effect then.
- fifo_rd_done is never asserted while fifo_data_available=0. The FIFO therefore never sees an underflow caused by this block.

## Timing
- Reset (reset_n=0 at a clock edge): state=IDLE, beat=0, hold=0, rd_done_q=0, entries_sent=0, fifo_error_sticky=0. All outputs are 0: tx_valid, tx_data, tx_first, tx_last, tx_bad, fifo_rd_done.
- Reset mid-entry abandons the entry. It was already popped, so it is lost, and no further beats are emitted.
- Latency: capture at cycle N, first beat valid at N+1.
- With tx_ready held at 1, an entry occupies exactly NUM_BEATS cycles. Sustained throughput is one entry per NUM_BEATS cycles.
- Pop spacing: at least NUM_BEATS cycles between fifo_rd_done pulses. Since NUM_BEATS≥2, the blanking cycle never stalls back-to-back operation.
- fifo_error_sticky is registered: it rises on the edge following an error pulse.
- entries_sent is registered: it updates on the edge at which the last beat is accepted.

## Structure
- Shared package/include ocx_tlx_fifo_pkg holds:
  - ENTRY_WIDTH=513, PAYLOAD_WIDTH=512, BAD_BIT=512
  - state encodings IDLE=1'b0, SEND=1'b1
- The FIFO pair (inferred regfile plus ocx_tlx_fifo_cntlr) stays in the parent.
- No sub-module inside this block. The beat mux is an indexed part-select, not a separate module.

## Test plan
- Single entry, BEAT_WIDTH=128, tx_ready=1:
  - stimulus: entry with payload = {4{32'hA5A5_0000 + i}} per 128-bit lane, bit512=0
  - required: one fifo_rd_done pulse; 4 consecutive beats, lane 0 first; tx_first on beat 0 only, tx_last on beat 3 only; entries_sent=1; return to IDLE.
- Back-to-back:
  - stimulus: 3 entries queued, the second with bit512=1
  - required: 12 beats with no tx_valid gap; fifo_rd_done pulses exactly 4 cycles apart; tx_bad=1 on beats 4-7 only; entries_sent=3.
- Backpressure:
  - stimulus: tx_ready toggles 1,0,0,1,… through an entry
  - required: data, first, last and bad are held stable while stalled; no beat is skipped or duplicated; no pop occurs until the last beat is accepted.
- Stale-availability guard:
  - stimulus: FIFO model keeps fifo_data_available=1 for one cycle after the final pop, then drops it
  - required: no second fifo_rd_done; block goes to IDLE.
- Reset and errors:
  - stimulus: reset_n=0 during beat 2, then pulse fifo_overflow_error
  - required: all outputs 0 on the edge after reset; fifo_error_sticky=1 from the edge after the pulse; entries_sent unchanged at 0.
- Wrap:
  - stimulus: preload entries_sent=0xFFFF via forced start, then send one entry
  - required: entries_sent=0x0000.

Source files
------------

// File: rtl/ocx_tlx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_fifo_pkg
// Description : Shared definitions for the TLX data-FIFO read side: entry
//               geometry (512-bit payload plus a bad-data flag) and the
//               drain serializer state encoding.
// Contents    : ENTRY_WIDTH, PAYLOAD_WIDTH, BAD_BIT, state_t, num_beats()
// Revision    : 1.0 - initial release
// ============================================================================
package ocx_tlx_fifo_pkg;

    localparam int ENTRY_WIDTH   = 513;
    localparam int PAYLOAD_WIDTH = 512;
    localparam int BAD_BIT       = 512;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Beats needed to move one payload at a given beat width.
    function automatic int num_beats(input int beat_width);
        return PAYLOAD_WIDTH / beat_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ocx_tlx_fifo_drain_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_fifo_drain_serializer_if
// Description : Bundles the FIFO read-side signals, the beat stream toward
//               the transmit framer and the status outputs of the drain
//               serializer.
// Modports    : master - the serializer (pops FIFO, drives beat stream)
//               slave  - the surroundings (FIFO + framer)
// Signals     : fifo_data_out[512:0], fifo_data_available,
//               fifo_data_look_ahead, fifo_underflow_error,
//               fifo_overflow_error, fifo_rd_done, tx_valid, tx_ready,
//               tx_data[BEAT_WIDTH-1:0], tx_first, tx_last, tx_bad,
//               entries_sent[15:0], fifo_error_sticky
// Revision    : 1.0 - initial release
// ============================================================================
interface ocx_tlx_fifo_drain_serializer_if #(
    parameter int BEAT_WIDTH = 128
);
    import ocx_tlx_fifo_pkg::*;

    logic [ENTRY_WIDTH-1:0] fifo_data_out;
    logic                   fifo_data_available;
    logic                   fifo_data_look_ahead;
    logic                   fifo_underflow_error;
    logic                   fifo_overflow_error;
    logic                   fifo_rd_done;

    logic                   tx_valid;
    logic                   tx_ready;
    logic [BEAT_WIDTH-1:0]  tx_data;
    logic                   tx_first;
    logic                   tx_last;
    logic                   tx_bad;

    logic [15:0]            entries_sent;
    logic                   fifo_error_sticky;

    modport master (
        input  fifo_data_out, fifo_data_available, fifo_data_look_ahead,
               fifo_underflow_error, fifo_overflow_error, tx_ready,
        output fifo_rd_done, tx_valid, tx_data, tx_first, tx_last, tx_bad,
               entries_sent, fifo_error_sticky
    );

    modport slave (
        output fifo_data_out, fifo_data_available, fifo_data_look_ahead,
               fifo_underflow_error, fifo_overflow_error, tx_ready,
        input  fifo_rd_done, tx_valid, tx_data, tx_first, tx_last, tx_bad,
               entries_sent, fifo_error_sticky
    );

endinterface
`default_nettype wire

// File: rtl/ocx_tlx_fifo_drain_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_fifo_drain_serializer
// Description : Pops 513-bit entries from the TLX data FIFO and streams the
//               512-bit payload as NUM_BEATS beats of BEAT_WIDTH bits on a
//               valid/ready interface. Bit 512 (bad data) rides along on
//               every beat of its entry. Back-to-back entries stream with no
//               bubble when the next entry is already waiting.
// Parameters  : BEAT_WIDTH - 64, 128 or 256
// Ports       : clock   - single clock
//               reset_n - synchronous, active-low reset
//               bus     - master side of ocx_tlx_fifo_drain_serializer_if
// Revision    : 1.0 - initial release
// ============================================================================
module ocx_tlx_fifo_drain_serializer
    import ocx_tlx_fifo_pkg::*;
#(
    parameter int BEAT_WIDTH = 128
) (
    input  wire logic                        clock,
    input  wire logic                        reset_n,
    ocx_tlx_fifo_drain_serializer_if.master  bus
);

    localparam int                   NUM_BEATS = num_beats(BEAT_WIDTH);
    localparam int                   BEAT_BITS = $clog2(NUM_BEATS);
    localparam int                   LANE_BITS = $clog2(BEAT_WIDTH);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(NUM_BEATS - 1);

    state_t                   state_q, state_d;
    logic [ENTRY_WIDTH-1:0]   hold_q, hold_d;
    logic [BEAT_BITS-1:0]     beat_q, beat_d;
    logic                     rd_done_q, rd_done_d;
    logic [15:0]              entries_sent_q, entries_sent_d;
    logic                     fifo_error_sticky_q, fifo_error_sticky_d;

    logic                     in_send;
    logic                     capture_ok;
    logic                     accept;
    logic                     last_beat;
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [8:0]               beat_base;
    logic                     unused_look_ahead;

    // Look-ahead is informational only; nothing here depends on it.
    assign unused_look_ahead = bus.fifo_data_look_ahead;

    assign in_send   = (state_q == SEND);
    assign last_beat = (beat_q == LAST_BEAT);
    assign accept    = in_send & bus.tx_ready;

    // The cycle after a pop the FIFO head is still the old entry, so
    // capture is blanked then. Gating with reset_n keeps a pop from being
    // issued while the block is held in reset.
    assign capture_ok = bus.fifo_data_available & ~rd_done_q & reset_n;

    // BEAT_WIDTH is a power of two, so the lane offset is the beat index
    // shifted left; 9 bits exactly address the 512-bit payload.
    assign payload   = hold_q[PAYLOAD_WIDTH-1:0];
    assign beat_base = {beat_q, {LANE_BITS{1'b0}}};

    always_comb begin
        state_d             = state_q;
        hold_d              = hold_q;
        beat_d              = beat_q;
        rd_done_d           = 1'b0;
        entries_sent_d      = entries_sent_q;
        fifo_error_sticky_d = fifo_error_sticky_q
                            | bus.fifo_underflow_error
                            | bus.fifo_overflow_error;

        case (state_q)
            IDLE: begin
                if (capture_ok) begin
                    hold_d    = bus.fifo_data_out;
                    beat_d    = '0;
                    rd_done_d = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (last_beat) begin
                        entries_sent_d = entries_sent_q + 16'd1;
                        if (capture_ok) begin
                            // Next entry is ready: reload without a bubble.
                            hold_d    = bus.fifo_data_out;
                            beat_d    = '0;
                            rd_done_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_BITS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q             <= IDLE;
            hold_q              <= '0;
            beat_q              <= '0;
            rd_done_q           <= 1'b0;
            entries_sent_q      <= '0;
            fifo_error_sticky_q <= 1'b0;
        end else begin
            state_q             <= state_d;
            hold_q              <= hold_d;
            beat_q              <= beat_d;
            rd_done_q           <= rd_done_d;
            entries_sent_q      <= entries_sent_d;
            fifo_error_sticky_q <= fifo_error_sticky_d;
        end
    end

    // Beat outputs are forced to zero outside SEND so an idle stream
    // presents no stale payload.
    assign bus.tx_valid          = in_send;
    assign bus.tx_data           = in_send ? payload[beat_base +: BEAT_WIDTH] : '0;
    assign bus.tx_first          = in_send & (beat_q == '0);
    assign bus.tx_last           = in_send & last_beat;
    assign bus.tx_bad            = in_send & hold_q[BAD_BIT];
    assign bus.fifo_rd_done      = rd_done_d;
    assign bus.entries_sent      = entries_sent_q;
    assign bus.fifo_error_sticky = fifo_error_sticky_q;

endmodule
`default_nettype wire
